// File: rtl/mopshub_elink_pkg.sv
// Shared definitions for the e-link uplink receiver.
//   IDLE/SOP/EOP : 8-bit control codes carried on the e-link
//   FRAME_BYTES  : payload bytes between SOP and EOP
//   WORD_W       : width of the assembled payload word (FRAME_BYTES*8)
//   PAYLOAD_W    : width of the delivered payload (low bits of the word)
//   rx_state_e   : frame receiver states
package mopshub_elink_pkg;

  localparam logic [7:0] IDLE = 8'h7C;
  localparam logic [7:0] SOP  = 8'h3C;
  localparam logic [7:0] EOP  = 8'hBC;

  localparam int FRAME_BYTES = 10;
  localparam int WORD_W      = FRAME_BYTES * 8;
  localparam int PAYLOAD_W   = 76;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_IDLE_LOCKED,
    ST_PAYLOAD,
    ST_EOP_CHK
  } rx_state_e;

  // True for any of the three control codes; these never appear as payload.
  function automatic logic is_kchar(input logic [7:0] b);
    return (b == IDLE) || (b == SOP) || (b == EOP);
  endfunction

endpackage

// File: rtl/elink_byte_aligner.sv
// Byte alignment for the e-link dibit stream.
// Shifts one dibit per clock into an 8-bit register, hunts for the IDLE code
// at every dibit offset, and once LOCK_CNT consecutive IDLE bytes are seen at
// one phase it declares lock and strobes each completed byte.
//   clk, rst     : clock, asynchronous active-high reset
//   rx_elink2bit : incoming dibit, bit [1] earlier
//   unlock       : request from the frame FSM to drop lock and hunt again
//   rx_byte      : current aligned byte (meaningful when byte_stb=1)
//   byte_stb     : one-cycle strobe per completed byte while locked
//   sync_locked  : alignment locked
module elink_byte_aligner
  import mopshub_elink_pkg::*;
#(
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rx_elink2bit,
  input  logic       unlock,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       sync_locked
);

  localparam int LCW = $clog2(LOCK_CNT + 1);

  logic [7:0]     sreg_q, sreg_d;
  logic [1:0]     phase_q, phase_d;
  logic           anchored_q, anchored_d;
  logic           locked_q, locked_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           byte_done;

  // Phase 3 is the fourth clock after the anchor: the register then holds
  // exactly one new byte.
  assign byte_done = (anchored_q || locked_q) && (phase_q == 2'd3);

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sreg_d     = {sreg_q[5:0], rx_elink2bit};
    phase_d    = phase_q + 2'd1;
    anchored_d = anchored_q;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;

    if (locked_q) begin
      if (unlock) begin
        locked_d   = 1'b0;
        anchored_d = 1'b0;
        lock_cnt_d = '0;
      end
    end else if (!anchored_q) begin
      // Free search: any clock may become the byte boundary.
      if (sreg_q == IDLE) begin
        anchored_d = 1'b1;
        phase_d    = 2'd0;
        lock_cnt_d = LCW'(1);
        if (LOCK_CNT <= 1) locked_d = 1'b1;
      end
    end else if (byte_done) begin
      if (sreg_q == IDLE) begin
        if (lock_cnt_q >= LCW'(LOCK_CNT - 1)) begin
          locked_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end else begin
        anchored_d = 1'b0;
        lock_cnt_d = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q     <= '0;
      phase_q    <= '0;
      anchored_q <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      sreg_q     <= sreg_d;
      phase_q    <= phase_d;
      anchored_q <= anchored_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign rx_byte     = sreg_q;
  assign byte_stb    = locked_q && (phase_q == 2'd3);
  assign sync_locked = locked_q;

endmodule

// File: rtl/elink_uplink_rx.sv
// E-link uplink frame receiver.
// Aligns the dibit stream to bytes, then parses SOP + 10 payload bytes + EOP.
// Accepted frames deliver the low 76 bits of the 80-bit word; frames with a
// misplaced control code, a bad EOP or a non-zero top nibble are discarded.
//   clk, rst     : clock, asynchronous active-high reset
//   rx_elink2bit : serial dibit input, MSB first
//   data_rec_out : payload of the last accepted frame (held)
//   data_valid   : one-cycle pulse when data_rec_out updates
//   frame_err    : one-cycle pulse when a frame is discarded
//   sync_locked  : byte alignment locked
//   frame_cnt    : accepted frames, wrapping
//   err_cnt      : discarded frames, saturating
module elink_uplink_rx
  import mopshub_elink_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           rx_elink2bit,
  output logic [PAYLOAD_W-1:0] data_rec_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 sync_locked,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           err_cnt
);

  localparam int ICW = $clog2(UNLOCK_CNT + 1);

  logic [7:0] rx_byte;
  logic       byte_stb;
  logic       unlock;

  elink_byte_aligner #(
    .LOCK_CNT (LOCK_CNT)
  ) u_aligner (
    .clk          (clk),
    .rst          (rst),
    .rx_elink2bit (rx_elink2bit),
    .unlock       (unlock),
    .rx_byte      (rx_byte),
    .byte_stb     (byte_stb),
    .sync_locked  (sync_locked)
  );

  rx_state_e            state_q, state_d;
  logic [3:0]           byte_cnt_q, byte_cnt_d;
  logic [ICW-1:0]       inv_cnt_q, inv_cnt_d;
  logic [WORD_W-1:0]    payload_q, payload_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 accept, discard;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    payload_d  = payload_q;
    unlock     = 1'b0;
    accept     = 1'b0;
    discard    = 1'b0;

    case (state_q)
      ST_HUNT: begin
        inv_cnt_d = '0;
        if (sync_locked) state_d = ST_IDLE_LOCKED;
      end

      ST_IDLE_LOCKED: begin
        if (byte_stb) begin
          if (rx_byte == IDLE) begin
            inv_cnt_d = '0;
          end else if (rx_byte == SOP) begin
            inv_cnt_d  = '0;
            byte_cnt_d = '0;
            state_d    = ST_PAYLOAD;
          end else if (inv_cnt_q >= ICW'(UNLOCK_CNT - 1)) begin
            unlock    = 1'b1;
            inv_cnt_d = '0;
            state_d   = ST_HUNT;
          end else begin
            inv_cnt_d = inv_cnt_q + ICW'(1);
          end
        end
      end

      ST_PAYLOAD: begin
        if (byte_stb) begin
          if (is_kchar(rx_byte)) begin
            // A control code inside the payload aborts; SOP also opens a
            // fresh frame immediately.
            discard = 1'b1;
            if (rx_byte == SOP) begin
              byte_cnt_d = '0;
            end else begin
              state_d = ST_IDLE_LOCKED;
            end
          end else begin
            payload_d = {payload_q[WORD_W-9:0], rx_byte};
            if (byte_cnt_q == 4'(FRAME_BYTES - 1)) begin
              state_d = ST_EOP_CHK;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end
        end
      end

      ST_EOP_CHK: begin
        if (byte_stb) begin
          state_d = ST_IDLE_LOCKED;
          if ((rx_byte == EOP) && (payload_q[WORD_W-1:PAYLOAD_W] == '0)) begin
            accept = 1'b1;
          end else begin
            discard = 1'b1;
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase

    // Losing lock by any route returns the parser to HUNT.
    if (!sync_locked && !unlock) state_d = ST_HUNT;
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = accept;
    ferr_d      = discard;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      data_d      = payload_q[PAYLOAD_W-1:0];
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (discard && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // NOTE: the payload and output data registers are reset along with the
  // control state so a partial frame never leaks after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      byte_cnt_q  <= '0;
      inv_cnt_q   <= '0;
      payload_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      inv_cnt_q   <= inv_cnt_d;
      payload_q   <= payload_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_rec_out = data_q;
  assign data_valid   = valid_q;
  assign frame_err    = ferr_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_elink_uplink_rx.sv
module tb_elink_uplink_rx;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam logic [7:0] K_IDLE = 8'h7C;
  localparam logic [7:0] K_SOP  = 8'h3C;
  localparam logic [7:0] K_EOP  = 8'hBC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rx  = 2'b00;
  logic [75:0] data_rec_out;
  logic        data_valid;
  logic        frame_err;
  logic        sync_locked;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  elink_uplink_rx #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_elink2bit (rx),
    .data_rec_out (data_rec_out),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .sync_locked  (sync_locked),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int obs_valid = 0;
  int obs_err = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Alignment is tracked by cycle arithmetic from the anchor clock; frames
  // are collected as a byte queue and judged when the closing byte arrives.
  int          m_cyc = 0;
  int          m_win = 0;
  bit          m_locked = 0, m_anch = 0;
  int          m_anchor = 0, m_lcnt = 0, m_inv = 0;
  bit          m_in_frame = 0;
  logic [7:0]  m_q[$];
  logic [75:0] m_data = '0;
  bit          m_valid = 0, m_ferr = 0;
  int          m_fcnt = 0, m_ecnt = 0;

  function automatic bit is_k(input logic [7:0] b);
    return (b == K_IDLE) || (b == K_SOP) || (b == K_EOP);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_win = 0; m_locked = 0; m_anch = 0; m_anchor = 0;
    m_lcnt = 0; m_inv = 0; m_in_frame = 0; m_q.delete();
    m_data = '0; m_valid = 0; m_ferr = 0; m_fcnt = 0; m_ecnt = 0;
  endtask

  task automatic model_discard();
    m_ferr = 1;
    if (m_ecnt < 255) m_ecnt++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [79:0] w;
    if (!m_in_frame) begin
      if (b == K_IDLE) m_inv = 0;
      else if (b == K_SOP) begin
        m_inv = 0; m_in_frame = 1; m_q.delete();
      end else begin
        m_inv++;
        if (m_inv >= UNLOCK_CNT) begin
          m_inv = 0; m_locked = 0; m_anch = 0; m_lcnt = 0;
        end
      end
    end else if (m_q.size() < 10) begin
      if (is_k(b)) begin
        model_discard();
        if (b == K_SOP) m_q.delete();
        else m_in_frame = 0;
      end else m_q.push_back(b);
    end else begin
      w = '0;
      foreach (m_q[i]) w = (w << 8) | 80'(m_q[i]);
      if (b == K_EOP && w[79:76] == 4'h0) begin
        m_data = w[75:0]; m_valid = 1; m_fcnt = (m_fcnt + 1) % 65536;
      end else model_discard();
      m_in_frame = 0;
    end
  endtask

  task automatic model_step(input logic [1:0] d);
    m_valid = 0; m_ferr = 0;
    if (!m_locked) begin
      if (!m_anch) begin
        if (m_win == int'(K_IDLE)) begin
          m_anch = 1; m_anchor = m_cyc; m_lcnt = 1;
          if (m_lcnt >= LOCK_CNT) m_locked = 1;
        end
      end else if ((m_cyc - m_anchor) % 4 == 0) begin
        if (m_win == int'(K_IDLE)) begin
          m_lcnt++;
          if (m_lcnt >= LOCK_CNT) m_locked = 1;
        end else begin
          m_anch = 0; m_lcnt = 0;
        end
      end
    end else if ((m_cyc - m_anchor) % 4 == 0) begin
      model_byte(8'(m_win));
    end
    m_win = ((m_win << 2) | int'(d)) & 255;
    m_cyc++;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step(rx);
  end

  // Single compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("data_valid",   80'(data_valid),   80'(m_valid));
    check("frame_err",    80'(frame_err),    80'(m_ferr));
    check("sync_locked",  80'(sync_locked),  80'(m_locked));
    check("frame_cnt",    80'(frame_cnt),    80'(m_fcnt));
    check("err_cnt",      80'(err_cnt),      80'(m_ecnt));
    check("data_rec_out", 80'(data_rec_out), 80'(m_data));
    if (data_valid === 1'b1) obs_valid++;
    if (frame_err === 1'b1) obs_err++;
  end

  // ---------------- stimulus ----------------
  task automatic send_dibit(input logic [1:0] d);
    @(posedge clk);
    #1 rx = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) send_dibit(b[2*i +: 2]);
  endtask

  task automatic send_idles(input int n);
    for (int i = 0; i < n; i++) send_byte(K_IDLE);
  endtask

  task automatic send_frame(input logic [79:0] w, input logic [7:0] close);
    send_byte(K_SOP);
    for (int i = 9; i >= 0; i--) send_byte(w[8*i +: 8]);
    send_byte(close);
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_k(b));
    return b;
  endfunction

  function automatic logic [79:0] rand_word(input bit good);
    logic [79:0] w;
    logic [7:0]  top;
    w = '0;
    if (good) top = rand_data() & 8'h0F;
    else do top = rand_data(); while (top[7:4] == 4'h0);
    w[79:72] = top;
    for (int i = 8; i >= 0; i--) w[8*i +: 8] = rand_data();
    return w;
  endfunction

  int v0, e0;

  initial begin
    logic [7:0] kpick;
    int kind, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sync_locked", 80'(sync_locked), 80'(0));
    check("rst_frame_cnt",   80'(frame_cnt),   80'(0));
    check("rst_data",        80'(data_rec_out), 80'(0));
    rst = 1'b0;

    // Lock on 4 IDLE bytes at dibit offset 1, exactly after the 4th byte
    send_dibit(2'b00);
    send_idles(4);
    send_dibit(2'b01);
    check("lock_not_early", 80'(sync_locked), 80'(0));
    send_dibit(2'b11);
    check("lock_after_4th", 80'(sync_locked), 80'(1));
    send_dibit(2'b11);
    send_dibit(2'b00);
    check("lock_frame_cnt", 80'(frame_cnt), 80'(0));

    // Valid frame
    send_idles(2);
    v0 = obs_valid; e0 = obs_err;
    send_frame(80'h0123456789ABCDEF0123, K_EOP);
    send_idles(3);
    check("f1_data",   80'(data_rec_out), 80'(76'h123456789ABCDEF0123));
    check("f1_cnt",    80'(frame_cnt), 80'(1));
    check("f1_pulses", 80'(obs_valid - v0), 80'(1));
    check("f1_noerr",  80'(obs_err - e0), 80'(0));

    // Non-zero top nibble -> discard
    v0 = obs_valid; e0 = obs_err;
    send_frame(80'hF0112233445566778899, K_EOP);
    send_idles(3);
    check("nib_err_cnt", 80'(err_cnt), 80'(1));
    check("nib_data",    80'(data_rec_out), 80'(76'h123456789ABCDEF0123));
    check("nib_novalid", 80'(obs_valid - v0), 80'(0));
    check("nib_errpulse", 80'(obs_err - e0), 80'(1));

    // SOP restart in the middle of a frame
    v0 = obs_valid; e0 = obs_err;
    send_byte(K_SOP);
    for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1));
    send_frame(80'h0A1B2C3D4E5F60718293, K_EOP);
    send_idles(3);
    check("restart_err",   80'(obs_err - e0), 80'(1));
    check("restart_valid", 80'(obs_valid - v0), 80'(1));
    check("restart_data",  80'(data_rec_out), 80'(76'hA1B2C3D4E5F60718293));
    check("restart_cnt",   80'(frame_cnt), 80'(2));

    // Loss of lock on 3 invalid bytes, then relock
    send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
    send_dibit(2'b01);
    check("unlock_not_early", 80'(sync_locked), 80'(1));
    send_dibit(2'b11);
    check("unlock_after_3rd", 80'(sync_locked), 80'(0));
    send_dibit(2'b11);
    send_dibit(2'b00);
    send_idles(4);
    check("relock", 80'(sync_locked), 80'(1));

    // Reset in the middle of byte 6 of a frame
    send_idles(1);
    send_byte(K_SOP);
    for (int i = 0; i < 5; i++) send_byte(rand_data());
    send_dibit(2'b10);
    send_dibit(2'b01);
    e0 = obs_err;
    @(posedge clk);
    #1 rst = 1'b1; rx = 2'b00;
    #2;
    check("mid_rst_valid",  80'(data_valid),   80'(0));
    check("mid_rst_ferr",   80'(frame_err),    80'(0));
    check("mid_rst_lock",   80'(sync_locked),  80'(0));
    check("mid_rst_data",   80'(data_rec_out), 80'(0));
    check("mid_rst_counts", 80'({frame_cnt, err_cnt}), 80'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_no_ferr", 80'(obs_err - e0), 80'(0));
    send_idles(5);
    send_frame(80'h00FEDCBA987654321000, K_EOP);
    send_idles(3);
    check("post_rst_cnt",  80'(frame_cnt), 80'(1));
    check("post_rst_data", 80'(data_rec_out), 80'(76'hFEDCBA987654321000));

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0, 1: send_frame(rand_word(1), K_EOP);
        2:    send_frame(rand_word(0), K_EOP);
        3:    send_frame(rand_word(1), rand_data());
        4: begin
          send_byte(K_SOP);
          n = $urandom_range(0, 9);
          for (int i = 0; i < n; i++) send_byte(rand_data());
          case ($urandom_range(0, 2))
            0: kpick = K_IDLE;
            1: kpick = K_SOP;
            default: kpick = K_EOP;
          endcase
          send_byte(kpick);
        end
        5: begin
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) send_byte(rand_data());
          send_idles(6);
        end
        default: begin
          send_dibit(2'($urandom_range(0, 3)));
          send_idles(10);
        end
      endcase
      send_idles($urandom_range(1, 3));
    end
    send_idles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
